// File: rtl/uart_rx_frontend_if.sv
// Serial-receiver bundle: RX line in, received byte and status strobes out.
// Master side is the receiver, slave side is the downstream command parser.
// No backpressure: the consumer must take every o_valid / o_frame_err pulse.
interface uart_rx_frontend_if;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  modport master (
    input  i_rx,
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_busy
  );

  modport slave (
    output i_rx,
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_busy
  );
endinterface

// File: rtl/uart_rx_frontend.sv
// UART 8N1 receiver: synchronises RX, mid-bit sampling, byte / framing-error strobes.
// Latency: SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles from start edge to o_valid.
// No backpressure; UART_RX_PARITY_EN adds an even-parity bit (8E1) checked before the stop bit.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input logic               i_clk,
  input logic               i_rst,
  uart_rx_frontend_if.master rx_if
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] FULL_C = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_C = BW'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
`ifdef UART_RX_PARITY_EN
    , S_PARITY = 3'd5
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [BW-1:0]          baud_q, baud_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_err_q, par_err_d;
`endif

  // Metastability synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_if.i_rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers: baud/bit counters, shifter and output strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      baud_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      baud_q    <= baud_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  // Next-state logic: the baud counter restarts at every sample and state change.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (baud_q == HALF_C) begin
          baud_d = '0;
          idx_d  = '0;
          // Line high again at mid start bit: a glitch, not a frame.
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (baud_q == FULL_C) begin
          baud_d         = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (baud_q == FULL_C) begin
          baud_d    = '0;
          // Even parity: data plus parity bit must hold an even number of ones.
          par_err_d = ^{shift_q, rx_s};
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_q == FULL_C) begin
          baud_d = '0;
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (par_err_q) begin
            ferr_d  = 1'b1;
            state_d = S_IDLE;
`endif
          end else begin
            valid_d = 1'b1;
            data_d  = shift_q;
            state_d = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        // Held-low line: one error already flagged, wait quietly for idle.
        baud_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are masked during reset so none can escape in the reset cycle.
  assign rx_if.o_data      = data_q;
  assign rx_if.o_valid     = valid_q & ~i_rst;
  assign rx_if.o_frame_err = ferr_q & ~i_rst;
  assign rx_if.o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend with an expected-strobe queue.
// Strobes are popped and compared on the falling clock edge.
// Inputs change 1 time unit after the rising edge.
module tb_uart_rx_frontend;
  localparam int CPB = 8;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [7:0] last_data = 8'h00;

  uart_rx_frontend_if bus();

  uart_rx_frontend #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .rx_if (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.i_rx = b;
    repeat (CPB) tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    drive_bit(stop);
  endtask

  task automatic expect_valid(input logic [7:0] d);
    exp_t e;
    e.err  = 1'b0;
    e.data = d;
    sb.push_back(e);
    last_data = d;
  endtask

  task automatic expect_err();
    exp_t e;
    e.err  = 1'b1;
    e.data = last_data;
    sb.push_back(e);
  endtask

  // Strobe monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.o_valid || bus.o_frame_err) begin
      chk("strobe_exclusive", {31'd0, bus.o_valid & bus.o_frame_err}, 32'd0);
      chk("strobe_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_kind_err", {31'd0, bus.o_frame_err}, {31'd0, e.err});
        chk("strobe_data", {24'd0, bus.o_data}, {24'd0, e.data});
      end
    end
  end

  // Watchdog: the directed sequence is a few thousand cycles at most.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_rx = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_data", {24'd0, bus.o_data}, 32'd0);
    chk("reset_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("reset_ferr", {31'd0, bus.o_frame_err}, 32'd0);
    chk("reset_busy", {31'd0, bus.o_busy}, 32'd0);
    repeat (2 * CPB) tick();

    // Single frame 0xA5.
    expect_valid(8'hA5);
    send_byte(8'hA5, 1'b1, 1'b0);
    chk("busy_after_a5", {31'd0, bus.o_busy}, 32'd0);
    repeat (2 * CPB) tick();

    // Back-to-back frames, no idle gap.
    expect_valid(8'h00);
    expect_valid(8'hFF);
    expect_valid(8'h3C);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);
    repeat (2 * CPB) tick();
    chk("data_held_3c", {24'd0, bus.o_data}, 32'h3C);

    // 3-cycle low glitch: false start, back to idle without strobes.
    bus.i_rx = 1'b0;
    repeat (3) tick();
    bus.i_rx = 1'b1;
    repeat (2) tick();
    chk("glitch_busy_mid", {31'd0, bus.o_busy}, 32'd1);
    repeat (5) tick();
    chk("glitch_busy_end", {31'd0, bus.o_busy}, 32'd0);
    repeat (2 * CPB) tick();

    // Framing error followed by a held-low break: exactly one error.
    expect_err();
    send_byte(8'h55, 1'b0, 1'b0);
    bus.i_rx = 1'b0;
    repeat (40) tick();
    chk("break_data_held", {24'd0, bus.o_data}, 32'h3C);
    bus.i_rx = 1'b1;
    repeat (2 * CPB) tick();
    expect_valid(8'h12);
    send_byte(8'h12, 1'b1, 1'b0);
    repeat (2 * CPB) tick();

    // Reset during bit 4 of 0x81: frame dropped, outputs cleared.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h81 >> i));
    bus.i_rx = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    bus.i_rx = 1'b1;
    chk("midrst_data", {24'd0, bus.o_data}, 32'd0);
    chk("midrst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("midrst_ferr", {31'd0, bus.o_frame_err}, 32'd0);
    chk("midrst_busy", {31'd0, bus.o_busy}, 32'd0);
    rst = 1'b0;
    last_data = 8'h00;
    repeat (3 * CPB) tick();
    expect_valid(8'h81);
    send_byte(8'h81, 1'b1, 1'b0);
    repeat (2 * CPB) tick();

`ifdef UART_RX_PARITY_EN
    // Correct even parity accepted, wrong parity flagged.
    expect_valid(8'h07);
    send_byte(8'h07, 1'b1, 1'b0);
    repeat (2 * CPB) tick();
    expect_err();
    send_byte(8'h07, 1'b1, 1'b1);
    repeat (2 * CPB) tick();
    chk("parity_busy_end", {31'd0, bus.o_busy}, 32'd0);
`endif

    repeat (4 * CPB) tick();
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
